twiddle_angle_gen: RTL

- Upstream sequencer for the twiddle CORDIC rotator.
- For one FFT pass, emits the binary-angle sequence θ(k) = ∓(k·m mod N)·2³²/N at one angle per cycle, together with the CORDIC start vector (x_start, y_start).
- Also carries index, valid and last tags through a delay line matched to the rotator latency, so tags leave aligned with cosine/sine.
- Sits between the FFT stage controller and the rotator.

---
 rtl/twiddle_pkg.sv | 25 ++
 rtl/tw_tag_delay.sv | 58 +++++
 rtl/twiddle_angle_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/twiddle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_pkg
//  Description : Shared definitions for the twiddle angle sequencer: state
//                encoding, binary-angle constants and the CORDIC gain-
//                compensated start magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
package twiddle_pkg;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // Binary angles: 2^32 corresponds to a full turn
    localparam logic [31:0] ANG_90  = 32'h4000_0000;
    localparam logic [31:0] ANG_180 = 32'h8000_0000;

    // round(0.607253 * (2^15 - 1)): start magnitude that cancels CORDIC gain
    localparam int XSTART_GAIN = 19898;

endpackage
`default_nettype wire

// File: rtl/tw_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tw_tag_delay
//  Description : Fixed-depth shift register carrying {valid, last, index}
//                tags alongside the CORDIC rotator. Shifts every cycle; the
//                valid and last bits are cleared by the synchronous
//                active-low reset so no stale tag survives a reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tw_tag_delay
    import twiddle_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 10
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             src_valid,
    input  logic             src_last,
    input  logic [IDX_W-1:0] src_index,
    output logic             dly_valid,
    output logic             dly_last,
    output logic [IDX_W-1:0] dly_index
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;
    logic [IDX_W-1:0] r_index [DEPTH];

    // Control bits: shift every cycle, cleared on reset
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            r_valid[0] <= src_valid;
            r_last[0]  <= src_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    // Index payload: plain shift, qualified downstream by the valid bit
    always_ff @(posedge clock) begin
        r_index[0] <= src_index;
        for (int i = 1; i < DEPTH; i++) begin
            r_index[i] <= r_index[i-1];
        end
    end

    assign dly_valid = r_valid[DEPTH-1];
    assign dly_last  = r_last[DEPTH-1];
    assign dly_index = r_index[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/twiddle_angle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_angle_gen
//  Description : Emits one binary angle per cycle for an FFT pass,
//                theta(k) = -(k*m mod N) * 2^32/N, plus the CORDIC start
//                vector, and carries index/valid/last tags through a delay
//                line matched to the rotator latency.
//                Optional build macro TWIDDLE_INVERSE_EN adds an 'inverse'
//                input selecting +acc (IFFT twiddles) instead of -acc.
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_angle_gen
    import twiddle_pkg::*;
#(
    parameter int N_LOG2_MAX = 10,
    parameter int WIDTH      = 16,
    parameter int CORDIC_LAT = 16,
    parameter int XSTART     = XSTART_GAIN
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            fft_log2,
    input  logic [N_LOG2_MAX-1:0] step,
    input  logic                  hold,
`ifdef TWIDDLE_INVERSE_EN
    input  logic                  inverse,
`endif
    output logic [31:0]           angle,
    output logic                  angle_valid,
    output logic [WIDTH-1:0]      x_start,
    output logic [WIDTH-1:0]      y_start,
    output logic                  tw_valid,
    output logic [N_LOG2_MAX-1:0] tw_index,
    output logic                  tw_last,
    output logic                  busy,
    output logic                  done
);

    state_t                r_state;
    logic [31:0]           r_inc;
    logic [31:0]           r_acc;
    logic [31:0]           r_angle;
    logic [N_LOG2_MAX-1:0] r_k;
    logic [N_LOG2_MAX-1:0] r_k_max;
    logic [N_LOG2_MAX-1:0] r_index;
    logic                  r_angle_valid;
    logic                  r_last;
    logic                  r_inverse;

    logic                  w_accept;
    logic [4:0]            w_log2;
    logic [31:0]           w_inc_new;
    logic [N_LOG2_MAX-1:0] w_kmax_new;
    logic                  w_inv_new;
    logic                  w_emit;
    logic [31:0]           w_acc_cur;
    logic [31:0]           w_inc_cur;
    logic [N_LOG2_MAX-1:0] w_k_cur;
    logic [N_LOG2_MAX-1:0] w_kmax_cur;
    logic                  w_inv_cur;
    logic                  w_is_last;
    logic [31:0]           w_angle_next;
    logic                  w_done;
    logic                  w_dly_valid;
    logic                  w_dly_last;
    logic [N_LOG2_MAX-1:0] w_dly_index;

`ifdef TWIDDLE_INVERSE_EN
    assign w_inv_new = inverse;
`else
    assign w_inv_new = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && start;

    // Clamp requested size to the supported range [2, N_LOG2_MAX]
    always_comb begin
        w_log2 = {1'b0, fft_log2};
        if (fft_log2 < 4'd2) begin
            w_log2 = 5'd2;
        end else if (32'(fft_log2) > N_LOG2_MAX) begin
            w_log2 = 5'(N_LOG2_MAX);
        end
    end

    // Phase increment m * 2^32/N and last index N-1 for the pass being accepted
    assign w_inc_new  = 32'(step) << (6'd32 - {1'b0, w_log2});
    assign w_kmax_new = N_LOG2_MAX'((32'd1 << w_log2) - 32'd1);

    // The start cycle itself generates k=0, so the first angle is registered
    // on the accepting edge; during it the freshly computed setup is used.
    assign w_acc_cur  = w_accept ? 32'd0 : r_acc;
    assign w_k_cur    = w_accept ? '0 : r_k;
    assign w_inc_cur  = w_accept ? w_inc_new : r_inc;
    assign w_kmax_cur = w_accept ? w_kmax_new : r_k_max;
    assign w_inv_cur  = w_accept ? w_inv_new : r_inverse;

    assign w_emit       = (w_accept || (r_state == RUN)) && !hold;
    assign w_is_last    = (w_k_cur == w_kmax_cur);
    assign w_angle_next = w_inv_cur ? w_acc_cur : (32'd0 - w_acc_cur);

    assign w_done = (r_state == DRAIN) && w_dly_last;

    // Sequencer state, accumulator and registered angle output
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_inc         <= '0;
            r_acc         <= '0;
            r_k           <= '0;
            r_k_max       <= '0;
            r_inverse     <= 1'b0;
            r_angle       <= '0;
            r_angle_valid <= 1'b0;
            r_index       <= '0;
            r_last        <= 1'b0;
        end else begin
            r_angle_valid <= w_emit;
            r_last        <= w_emit && w_is_last;
            if (w_accept) begin
                r_state   <= RUN;
                r_inc     <= w_inc_new;
                r_k_max   <= w_kmax_new;
                r_inverse <= w_inv_new;
                r_acc     <= '0;
                r_k       <= '0;
            end
            if (w_emit) begin
                r_angle <= w_angle_next;
                r_index <= w_k_cur;
                r_acc   <= w_acc_cur + w_inc_cur;
                r_k     <= w_k_cur + N_LOG2_MAX'(1);
                if (w_is_last) begin
                    r_state <= DRAIN;
                end
            end
            if (w_done) begin
                r_state <= IDLE;
            end
        end
    end

    tw_tag_delay #(
        .DEPTH (CORDIC_LAT),
        .IDX_W (N_LOG2_MAX)
    ) u_tag_delay (
        .clock     (clock),
        .rst_n     (rst_n),
        .src_valid (r_angle_valid),
        .src_last  (r_last),
        .src_index (r_index),
        .dly_valid (w_dly_valid),
        .dly_last  (w_dly_last),
        .dly_index (w_dly_index)
    );

    assign angle       = r_angle;
    assign angle_valid = r_angle_valid;
    assign x_start     = WIDTH'(XSTART);
    assign y_start     = '0;
    assign tw_valid    = w_dly_valid;
    assign tw_last     = w_dly_valid && w_dly_last;
    assign tw_index    = w_dly_valid ? w_dly_index : '0;
    assign busy        = (r_state != IDLE);
    assign done        = w_done;

endmodule
`default_nettype wire
